smoke_inc_engine: RTL



---
 rtl/smoke_inc_engine_if.sv | 25 ++
 rtl/smoke_inc_engine.sv | 135 +++++++++++++
 2 files changed

// File: rtl/smoke_inc_engine_if.sv
// Request/response channel between the smoke BFM and the increment engine.
interface smoke_inc_engine_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_data;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  rsp_ovf;

  modport master (
    output req_valid, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_ovf
  );

  modport slave (
    input  req_valid, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_ovf
  );
endinterface

// File: rtl/smoke_inc_engine.sv
// Pipelined increment engine: returns value+1 with the request tag, through a
// fixed-latency pipeline into a response FIFO; a pending limit absorbs backpressure.
module smoke_inc_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  smoke_inc_engine_if.slave     bus,
  output logic [15:0]           op_count,
  output logic                  busy
);
  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $fatal(1, "smoke_inc_engine: LATENCY must be in 1..8");
  end
  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $fatal(1, "smoke_inc_engine: DEPTH must be in 2..16");
  end

  logic                  accept;
  logic                  pop;
  logic                  wr_en;
  logic [PW-1:0]         pending_q;
  logic [PW-1:0]         pending_d;
  logic [PW-1:0]         fifo_cnt_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;

  logic [LATENCY-1:0]    stg_vld_q;
  logic [LATENCY-1:0]    stg_ovf_q;
  logic [DATA_WIDTH-1:0] stg_data_q [LATENCY];
  logic [TAG_WIDTH-1:0]  stg_tag_q  [LATENCY];

  logic [DEPTH-1:0]      fifo_ovf_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag_q  [DEPTH];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Ready depends only on reset and registered occupancy, never on req_valid.
  assign bus.req_ready = !reset && (pending_q < PW'(DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (fifo_cnt_q != '0);
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign wr_en         = stg_vld_q[LATENCY-1];

  assign bus.rsp_data  = fifo_data_q[rd_ptr_q];
  assign bus.rsp_tag   = fifo_tag_q[rd_ptr_q];
  assign bus.rsp_ovf   = fifo_ovf_q[rd_ptr_q];

  always_comb begin
    pending_d = pending_q;
    case ({accept, pop})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
  end

  // Non-stalling pipeline: stage 0 captures the result, later stages shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      stg_vld_q <= '0;
      stg_ovf_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stg_data_q[i] <= '0;
        stg_tag_q[i]  <= '0;
      end
    end else begin
      stg_vld_q[0] <= accept;
      if (accept) begin
        stg_data_q[0] <= bus.req_data + DATA_WIDTH'(1);
        stg_tag_q[0]  <= bus.req_tag;
        stg_ovf_q[0]  <= (bus.req_data == '1);
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stg_vld_q[i]  <= stg_vld_q[i-1];
        stg_data_q[i] <= stg_data_q[i-1];
        stg_tag_q[i]  <= stg_tag_q[i-1];
        stg_ovf_q[i]  <= stg_ovf_q[i-1];
      end
    end
  end

  // Response FIFO; the pending limit guarantees a write never finds it full.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      fifo_ovf_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
      end
    end else begin
      if (wr_en) begin
        fifo_data_q[wr_ptr_q] <= stg_data_q[LATENCY-1];
        fifo_tag_q[wr_ptr_q]  <= stg_tag_q[LATENCY-1];
        fifo_ovf_q[wr_ptr_q]  <= stg_ovf_q[LATENCY-1];
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({wr_en, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + PW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - PW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Occupancy tracking and consumed-response counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      pending_q <= pending_d;
      busy      <= (pending_d != '0);
      if (pop) begin
        op_count <= op_count + 16'd1;
      end
    end
  end
endmodule
